song_sequencer: RTL and testbench

Note-sequencing controller between the music player's control unit and the note player. When play is enabled, it walks the selected song's ROM image one note at a time. For each note it issues a one-cycle `new_note` strobe with that note's pitch and duration, then waits for `note_done` before fetching the next note. After the last note it pulses `song_done` back to the control unit and rewinds to note 0.

---
 rtl/song_sequencer.sv | 129 ++++++++++++
 tb/tb_song_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Note sequencer: walks a song's ROM image one note at a time, handshaking each note with the player.
// Optional feature macro: SONG_END_MARKER_EN (a duration-0 ROM word ends the song early).
module song_sequencer #(
  parameter int IDX_W  = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      reset_player,
  input  logic [1:0]                song,
  output logic [IDX_W+1:0]          rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      new_note,
  input  logic                      note_done,
  output logic                      song_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_ROM  = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  state_t             state_r, state_next;
  logic [IDX_W-1:0]   index_r;
  logic [1:0]         song_q_r;
  logic [NOTE_W-1:0]  note_r;
  logic [DUR_W-1:0]   dur_r;
  logic               new_note_r;
  logic               song_done_r;
  logic               end_marker_s;

`ifdef SONG_END_MARKER_EN
  assign end_marker_s = (rom_data[DUR_W-1:0] == {DUR_W{1'b0}});
`else
  assign end_marker_s = 1'b0;
`endif

  // The song select is only live on the address bus during FETCH; elsewhere it is the latched copy.
  assign rom_addr  = (state_r == FETCH) ? {song, index_r} : {song_q_r, index_r};
  assign note      = note_r;
  assign duration  = dur_r;
  assign new_note  = new_note_r;
  assign song_done = song_done_r;

  // Next-state decode; a rewind request overrides every transition.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:      state_next = play ? FETCH : IDLE;
      FETCH:     state_next = WAIT_ROM;
      WAIT_ROM:  state_next = end_marker_s ? DONE : ISSUE;
      ISSUE:     state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (note_done) begin
          if (index_r == IDX_LAST) begin
            state_next = DONE;
          end else if (play) begin
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = WAIT_DONE;
        end
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (reset_player) begin
      state_next = IDLE;
    end else begin
      state_next = state_next;
    end
  end

  // State register plus the two strobes, registered from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      new_note_r  <= 1'b0;
      song_done_r <= 1'b0;
    end else begin
      state_r     <= state_next;
      new_note_r  <= (state_next == ISSUE);
      song_done_r <= (state_next == DONE);
    end
  end

  // Datapath: song latch, note/duration capture and the note index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_r  <= {IDX_W{1'b0}};
      song_q_r <= 2'd0;
      note_r   <= {NOTE_W{1'b0}};
      dur_r    <= {DUR_W{1'b0}};
    end else if (reset_player) begin
      index_r  <= {IDX_W{1'b0}};
      song_q_r <= 2'd0;
      note_r   <= {NOTE_W{1'b0}};
      dur_r    <= {DUR_W{1'b0}};
    end else begin
      case (state_r)
        FETCH:     song_q_r <= song;
        WAIT_ROM:  {note_r, dur_r} <= rom_data;
        // The last index never carries over; the rewind happens in DONE.
        WAIT_DONE: begin
          if (note_done && (index_r != IDX_LAST)) begin
            index_r <= index_r + IDX_W'(1);
          end else begin
            index_r <= index_r;
          end
        end
        DONE:      index_r <= {IDX_W{1'b0}};
        default:   index_r <= index_r;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: random ROM contents, reference model of the song walk,
// and a monitor that checks every new_note / song_done strobe against the expected-event queue.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic        reset_player;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        note_done;
  logic        song_done;

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .reset_player(reset_player),
    .song(song), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .duration(duration), .new_note(new_note), .note_done(note_done),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [5:0] n;
    logic [5:0] d;
  } ev_t;

  logic [11:0] rom_mem [128];
  ev_t         exp_q [$];
  ev_t         mon_e;
  logic [1:0]  m_song;
  logic [4:0]  m_idx;
  int          checks = 0;
  int          fails  = 0;
  int          nn_count = 0;
  int          sd_count = 0;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the next fetched word of the current song should produce.
  task automatic push_next(output bit marker_end);
    logic [11:0] w;
    w = rom_mem[{m_song, m_idx}];
    marker_end = 1'b0;
`ifdef SONG_END_MARKER_EN
    if (w[5:0] == 6'd0) begin
      exp_q.push_back('{1'b1, 6'd0, 6'd0});
      m_idx = 5'd0;
      marker_end = 1'b1;
      return;
    end
`endif
    exp_q.push_back('{1'b0, w[11:6], w[5:0]});
  endtask

  // kind: 0 paused, 1 song end after last note, 2 next note, 3 end marker hit
  task automatic model_note_done(input bit p, output int kind);
    bit me;
    kind = 0;
    if (m_idx == 5'd31) begin
      exp_q.push_back('{1'b1, 6'd0, 6'd0});
      m_idx = 5'd0;
      kind = 1;
    end else begin
      m_idx = m_idx + 5'd1;
      if (p) begin
        push_next(me);
        kind = me ? 3 : 2;
      end
    end
  endtask

  task automatic wait_new_note();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (new_note) begin
        ok = 1'b1;
        break;
      end
    end
    check("new_note_timeout", 32'(ok), 32'd1);
  endtask

  // Called in the ISSUE cycle (just after the strobe edge); finishes the note as the player would.
  task automatic play_one(input bit play_after);
    int gap;
    int kind;
    gap = $urandom_range(0, 3);
    repeat (2 + gap) @(negedge clk);
    play = play_after;
    note_done = 1'b1;
    model_note_done(play_after, kind);
    @(negedge clk);
    note_done = 1'b0;
    if (kind == 1) begin
      check("song_end_pulse", 32'(song_done), 32'd1);
      @(posedge clk); #1;
      check("song_end_clear", 32'(song_done), 32'd0);
      check("rewind_index", 32'(rom_addr[4:0]), 32'd0);
    end else if (kind != 0) begin
      @(posedge clk); #1;
      check("gap_quiet", 32'(new_note | song_done), 32'd0);
      @(posedge clk); #1;
      if (kind == 3) begin
        check("marker_song_done", 32'(song_done), 32'd1);
        @(negedge clk);
        play = 1'b0;
      end else begin
        check("inter_note_latency", 32'(new_note), 32'd1);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the expected-event queue.
  always @(posedge clk) begin
    #1;
    if (reset && (new_note || song_done)) begin
      if (new_note) nn_count++;
      if (song_done) sd_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({new_note, song_done}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'({new_note, song_done}), mon_e.is_done ? 32'd1 : 32'd2);
        if (!mon_e.is_done) begin
          check("note_value", 32'(note), 32'(mon_e.n));
          check("duration_value", 32'(duration), 32'(mon_e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit me;
    for (int i = 0; i < 128; i++) begin
      rom_mem[i] = {6'($urandom), 6'($urandom_range(1, 63))};
    end
    rom_mem[7'h25][5:0] = 6'd0;

    reset = 1'b0; play = 1'b0; reset_player = 1'b0; song = 2'd0; note_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_note", 32'(note), 32'd0);
    check("reset_duration", 32'(duration), 32'd0);
    check("reset_new_note", 32'(new_note), 32'd0);
    check("reset_song_done", 32'(song_done), 32'd0);
    reset = 1'b1;

    // Basic start on song 2
    @(negedge clk);
    song = 2'd2; play = 1'b1; m_song = 2'd2; m_idx = 5'd0;
    push_next(me);
    @(posedge clk); #1;
    check("start_fetch_addr", 32'(rom_addr), 32'h40);
    @(posedge clk); #1;
    check("start_wait_rom", 32'(new_note), 32'd0);
    @(posedge clk); #1;
    check("start_latency", 32'(new_note), 32'd1);

    // Notes 0..2 back-to-back, pause during note 3
    for (int i = 0; i < 3; i++) play_one(1'b1);
    play_one(1'b0);
    repeat (2) @(negedge clk);
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
    repeat (2) @(negedge clk);
    play = 1'b1;
    push_next(me);
    @(posedge clk); #1;
    check("resume_addr", 32'(rom_addr), 32'h44);
    wait_new_note();
    for (int i = 4; i < 31; i++) play_one(1'b1);
    play_one(1'b0);
    check("song_note_count", 32'(nn_count), 32'd32);
    check("song_done_count", 32'(sd_count), 32'd1);

    // Priority: reset_player beats note_done and play in WAIT_DONE
    @(negedge clk);
    song = 2'd0; play = 1'b1; m_song = 2'd0; m_idx = 5'd0;
    push_next(me);
    wait_new_note();
    play_one(1'b1);
    play_one(1'b1);
    repeat (2) @(negedge clk);
    note_done = 1'b1; reset_player = 1'b1;
    m_idx = 5'd0;
    push_next(me);
    @(posedge clk); #1;
    check("prio_new_note", 32'(new_note), 32'd0);
    check("prio_song_done", 32'(song_done), 32'd0);
    check("prio_note", 32'(note), 32'd0);
    check("prio_duration", 32'(duration), 32'd0);
    check("prio_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    note_done = 1'b0; reset_player = 1'b0;
    wait_new_note();

    // Async reset while in WAIT_ROM
    repeat (2) @(negedge clk);
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0; play = 1'b0;
    #1;
    check("async_rom_addr", 32'(rom_addr), 32'd0);
    check("async_note", 32'(note), 32'd0);
    check("async_duration", 32'(duration), 32'd0);
    check("async_new_note", 32'(new_note), 32'd0);
    check("async_song_done", 32'(song_done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Restart from index 0 on song 1, which carries a duration-0 word at index 5
    @(negedge clk);
    song = 2'd1; play = 1'b1; m_song = 2'd1; m_idx = 5'd0;
    push_next(me);
    @(posedge clk); #1;
    check("restart_addr", 32'(rom_addr), 32'h20);
    wait_new_note();
    for (int i = 0; i < 5; i++) play_one(1'b1);
`ifndef SONG_END_MARKER_EN
    play_one(1'b0);
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
